// File: rtl/id_stage_pipelined.sv
// Decode stage: register file with writeback bypass, condition check, control decode,
// RAW hazard detection and the ID/EX pipeline register feeding execute.
module id_stage_pipelined #(
    parameter int unsigned WORD_WIDTH    = 32,
    parameter int unsigned REG_COUNT     = 16,
    parameter int unsigned FORWARDING_EN = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic [WORD_WIDTH-1:0] pc_in,
    input  logic [31:0]           instruction_in,
    input  logic [3:0]            status_register,
    input  logic                  wb_en,
    input  logic [3:0]            wb_dst,
    input  logic [WORD_WIDTH-1:0] wb_data,
    input  logic                  exe_wb_en,
    input  logic [3:0]            exe_dst,
    input  logic                  exe_mem_read,
    input  logic                  mem_wb_en,
    input  logic [3:0]            mem_dst,
    output logic                  hazard_stall,
    output logic [WORD_WIDTH-1:0] pc_out,
    output logic [WORD_WIDTH-1:0] val_rn,
    output logic [WORD_WIDTH-1:0] val_rm,
    output logic [3:0]            src1,
    output logic [3:0]            src2,
    output logic [3:0]            dst,
    output logic [11:0]           shifter_operand,
    output logic [23:0]           signed_imm,
    output logic [3:0]            ex_cmd,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  wb_en_out,
    output logic                  imm,
    output logic                  b,
    output logic                  s_update,
    output logic                  valid
);

    localparam int unsigned RA_W  = 4;
    localparam int unsigned CMD_W = 4;
    localparam bit          FWD   = (FORWARDING_EN != 0);

    typedef struct packed {
        logic [WORD_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] val_rn;
        logic [WORD_WIDTH-1:0] val_rm;
        logic [RA_W-1:0]       src1;
        logic [RA_W-1:0]       src2;
        logic [RA_W-1:0]       dst;
        logic [11:0]           shifter_operand;
        logic [23:0]           signed_imm;
        logic [CMD_W-1:0]      ex_cmd;
        logic                  mem_read;
        logic                  mem_write;
        logic                  wb_en;
        logic                  imm;
        logic                  b;
        logic                  s_update;
        logic                  valid;
    } idex_t;

    logic [3:0]            cond;
    logic [1:0]            mode;
    logic [3:0]            opcode;
    logic [RA_W-1:0]       rn, rd, rm, src2_addr;
    logic                  imm_bit;
    logic                  n_f, z_f, c_f, v_f;
    logic                  cond_ok;
    logic                  dec_ok, dec_wb, dec_mem_rd, dec_mem_wr, dec_b, dec_s, dec_no_rn;
    logic [CMD_W-1:0]      dec_cmd;
    logic                  has_src1, has_src2;
    logic                  match_exe, match_mem, raw_hit;
    logic [WORD_WIDTH-1:0] rn_val, src2_val;
    logic [WORD_WIDTH-1:0] rf_q [REG_COUNT];
    idex_t                 idex_d, idex_q;

    assign cond      = instruction_in[31:28];
    assign mode      = instruction_in[27:26];
    assign imm_bit   = instruction_in[25];
    assign opcode    = instruction_in[24:21];
    assign rn        = instruction_in[19:16];
    assign rd        = instruction_in[15:12];
    assign rm        = instruction_in[3:0];
    assign src2_addr = dec_mem_wr ? rd : rm;
    assign {n_f, z_f, c_f, v_f} = status_register;

    // Condition evaluation on {N,Z,C,V}; code 1111 never passes
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'h0:    cond_ok = z_f;
            4'h1:    cond_ok = ~z_f;
            4'h2:    cond_ok = c_f;
            4'h3:    cond_ok = ~c_f;
            4'h4:    cond_ok = n_f;
            4'h5:    cond_ok = ~n_f;
            4'h6:    cond_ok = v_f;
            4'h7:    cond_ok = ~v_f;
            4'h8:    cond_ok = c_f & ~z_f;
            4'h9:    cond_ok = ~c_f | z_f;
            4'hA:    cond_ok = (n_f == v_f);
            4'hB:    cond_ok = (n_f != v_f);
            4'hC:    cond_ok = ~z_f & (n_f == v_f);
            4'hD:    cond_ok = z_f | (n_f != v_f);
            4'hE:    cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // Control decode; anything not recognised leaves dec_ok low and becomes a bubble
    always_comb begin
        dec_ok     = 1'b0;
        dec_cmd    = '0;
        dec_wb     = 1'b0;
        dec_mem_rd = 1'b0;
        dec_mem_wr = 1'b0;
        dec_b      = 1'b0;
        dec_s      = 1'b0;
        dec_no_rn  = 1'b0;
        case (mode)
            2'b00: begin
                dec_ok = 1'b1;
                dec_wb = 1'b1;
                dec_s  = instruction_in[20];
                case (opcode)
                    4'b1101: begin dec_cmd = 4'b0001; dec_no_rn = 1'b1; end
                    4'b1111: begin dec_cmd = 4'b1001; dec_no_rn = 1'b1; end
                    4'b0100: dec_cmd = 4'b0010;
                    4'b0101: dec_cmd = 4'b0011;
                    4'b0010: dec_cmd = 4'b0100;
                    4'b0110: dec_cmd = 4'b0101;
                    4'b0000: dec_cmd = 4'b0110;
                    4'b1100: dec_cmd = 4'b0111;
                    4'b0001: dec_cmd = 4'b1000;
                    4'b1010: begin dec_cmd = 4'b0100; dec_wb = 1'b0; dec_s = 1'b1; end
                    4'b1000: begin dec_cmd = 4'b0110; dec_wb = 1'b0; dec_s = 1'b1; end
                    default: begin dec_ok = 1'b0; dec_wb = 1'b0; dec_s = 1'b0; end
                endcase
            end
            2'b01: begin
                dec_ok     = 1'b1;
                dec_cmd    = 4'b0010;
                dec_mem_rd = instruction_in[20];
                dec_mem_wr = ~instruction_in[20];
                dec_wb     = instruction_in[20];
            end
            2'b10: begin
                dec_ok    = 1'b1;
                dec_b     = 1'b1;
                dec_no_rn = 1'b1;
            end
            default: ;
        endcase
    end

    assign has_src1 = ~dec_no_rn;
    assign has_src2 = ~imm_bit | dec_mem_wr;

    // Register file read with same-cycle writeback bypass; out-of-range addresses read 0
    always_comb begin
        rn_val   = '0;
        src2_val = '0;
        for (int i = 0; i < int'(REG_COUNT); i++) begin
            if (rn == 4'(i))
                rn_val = (wb_en && wb_dst == rn) ? wb_data : rf_q[i];
            if (src2_addr == 4'(i))
                src2_val = (wb_en && wb_dst == src2_addr) ? wb_data : rf_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_COUNT); i++) rf_q[i] <= '0;
        end else if (wb_en) begin
            for (int i = 0; i < int'(REG_COUNT); i++)
                if (wb_dst == 4'(i)) rf_q[i] <= wb_data;
        end
    end

    // RAW detection against in-flight producers
    assign match_exe = (has_src1 && rn == exe_dst) || (has_src2 && src2_addr == exe_dst);
    assign match_mem = (has_src1 && rn == mem_dst) || (has_src2 && src2_addr == mem_dst);

    always_comb begin
        raw_hit = 1'b0;
        if (FWD) raw_hit = exe_mem_read & match_exe;
        else     raw_hit = (exe_wb_en & match_exe) | (mem_wb_en & match_mem);
    end

    assign hazard_stall = ~flush & cond_ok & raw_hit;

    // ID/EX next state: flush beats freeze, which beats stall/condition bubbles
    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d = '0;
        end else if (!freeze) begin
            if (hazard_stall || !cond_ok || !dec_ok) begin
                idex_d = '0;
            end else begin
                idex_d.pc              = pc_in;
                idex_d.val_rn          = rn_val;
                idex_d.val_rm          = src2_val;
                idex_d.src1            = rn;
                idex_d.src2            = src2_addr;
                idex_d.dst             = rd;
                idex_d.shifter_operand = instruction_in[11:0];
                idex_d.signed_imm      = instruction_in[23:0];
                idex_d.ex_cmd          = dec_cmd;
                idex_d.mem_read        = dec_mem_rd;
                idex_d.mem_write       = dec_mem_wr;
                idex_d.wb_en           = dec_wb;
                idex_d.imm             = imm_bit;
                idex_d.b               = dec_b;
                idex_d.s_update        = dec_s;
                idex_d.valid           = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) idex_q <= '0;
        else     idex_q <= idex_d;
    end

    assign pc_out          = idex_q.pc;
    assign val_rn          = idex_q.val_rn;
    assign val_rm          = idex_q.val_rm;
    assign src1            = idex_q.src1;
    assign src2            = idex_q.src2;
    assign dst             = idex_q.dst;
    assign shifter_operand = idex_q.shifter_operand;
    assign signed_imm      = idex_q.signed_imm;
    assign ex_cmd          = idex_q.ex_cmd;
    assign mem_read        = idex_q.mem_read;
    assign mem_write       = idex_q.mem_write;
    assign wb_en_out       = idex_q.wb_en;
    assign imm             = idex_q.imm;
    assign b               = idex_q.b;
    assign s_update        = idex_q.s_update;
    assign valid           = idex_q.valid;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed bench for id_stage_pipelined: one stall-only and one forwarding-aware
// instance share all inputs; expected values are hand-computed.
module tb_id_stage_pipelined;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze, flush;
    logic [31:0] pc_in, instruction_in;
    logic [3:0]  status_register;
    logic        wb_en;
    logic [3:0]  wb_dst;
    logic [31:0] wb_data;
    logic        exe_wb_en, exe_mem_read, mem_wb_en;
    logic [3:0]  exe_dst, mem_dst;

    logic        hazard_stall;
    logic [31:0] pc_out, val_rn, val_rm;
    logic [3:0]  src1, src2, dst, ex_cmd;
    logic [11:0] shifter_operand;
    logic [23:0] signed_imm;
    logic        mem_read, mem_write, wb_en_out, imm, b, s_update, valid;

    logic        f_hazard_stall;
    logic [31:0] f_pc_out, f_val_rn, f_val_rm;
    logic [3:0]  f_src1, f_src2, f_dst, f_ex_cmd;
    logic [11:0] f_shifter_operand;
    logic [23:0] f_signed_imm;
    logic        f_mem_read, f_mem_write, f_wb_en_out, f_imm, f_b, f_s_update, f_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_stage_pipelined #(.WORD_WIDTH(32), .REG_COUNT(16), .FORWARDING_EN(0)) u_stall (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .pc_in(pc_in),
        .instruction_in(instruction_in), .status_register(status_register),
        .wb_en(wb_en), .wb_dst(wb_dst), .wb_data(wb_data),
        .exe_wb_en(exe_wb_en), .exe_dst(exe_dst), .exe_mem_read(exe_mem_read),
        .mem_wb_en(mem_wb_en), .mem_dst(mem_dst), .hazard_stall(hazard_stall),
        .pc_out(pc_out), .val_rn(val_rn), .val_rm(val_rm), .src1(src1), .src2(src2),
        .dst(dst), .shifter_operand(shifter_operand), .signed_imm(signed_imm),
        .ex_cmd(ex_cmd), .mem_read(mem_read), .mem_write(mem_write),
        .wb_en_out(wb_en_out), .imm(imm), .b(b), .s_update(s_update), .valid(valid)
    );

    id_stage_pipelined #(.WORD_WIDTH(32), .REG_COUNT(16), .FORWARDING_EN(1)) u_fwd (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .pc_in(pc_in),
        .instruction_in(instruction_in), .status_register(status_register),
        .wb_en(wb_en), .wb_dst(wb_dst), .wb_data(wb_data),
        .exe_wb_en(exe_wb_en), .exe_dst(exe_dst), .exe_mem_read(exe_mem_read),
        .mem_wb_en(mem_wb_en), .mem_dst(mem_dst), .hazard_stall(f_hazard_stall),
        .pc_out(f_pc_out), .val_rn(f_val_rn), .val_rm(f_val_rm), .src1(f_src1),
        .src2(f_src2), .dst(f_dst), .shifter_operand(f_shifter_operand),
        .signed_imm(f_signed_imm), .ex_cmd(f_ex_cmd), .mem_read(f_mem_read),
        .mem_write(f_mem_write), .wb_en_out(f_wb_en_out), .imm(f_imm), .b(f_b),
        .s_update(f_s_update), .valid(f_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] ins);
        pc_in          = pc;
        instruction_in = ins;
    endtask

    localparam logic [31:0] NOP     = 32'hF000_0000;  // cond 1111 never passes
    localparam logic [31:0] ADD_123 = 32'hE082_1003;  // ADD R1,R2,R3
    localparam logic [31:0] RSB_123 = 32'hE062_1003;  // unlisted opcode 0011
    localparam logic [31:0] SUB_42I = 32'hE242_4001;  // SUB R4,R2,#1
    localparam logic [31:0] MOVEQ03 = 32'h03A0_0003;  // MOVEQ R0,#3
    localparam logic [31:0] STR_12  = 32'hE582_1000;  // STR R1,[R2]
    localparam logic [31:0] LDR_12  = 32'hE592_1000;  // LDR R1,[R2]
    localparam logic [31:0] B_10    = 32'hEA00_0010;  // B +0x10
    localparam logic [31:0] CMP_23  = 32'hE142_0003;  // CMP R2,R3 (S bit clear)

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0;
        pc_in = '0; instruction_in = NOP; status_register = 4'b0000;
        wb_en = 1'b0; wb_dst = '0; wb_data = '0;
        exe_wb_en = 1'b0; exe_dst = '0; exe_mem_read = 1'b0;
        mem_wb_en = 1'b0; mem_dst = '0;
        step(); step();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_stall", 32'(hazard_stall), 32'd0);
        rst = 1'b0;

        // Preload R2=5, R3=7
        wb_en = 1'b1; wb_dst = 4'd2; wb_data = 32'd5;
        step();
        wb_dst = 4'd3; wb_data = 32'd7;
        step();
        wb_en = 1'b0;

        issue(32'h100, ADD_123);
        #1 chk("add_nostall", 32'(hazard_stall), 32'd0);
        step();
        chk("add_cmd", 32'(ex_cmd), 32'h2);
        chk("add_rn", val_rn, 32'd5);
        chk("add_rm", val_rm, 32'd7);
        chk("add_dst", 32'(dst), 32'd1);
        chk("add_wb", 32'(wb_en_out), 32'd1);
        chk("add_valid", 32'(valid), 32'd1);
        chk("add_pc", pc_out, 32'h100);
        chk("add_src2", 32'(src2), 32'd3);

        // Same-cycle writeback bypass of R2
        wb_en = 1'b1; wb_dst = 4'd2; wb_data = 32'hAA;
        issue(32'h104, ADD_123);
        step();
        chk("byp_rn", val_rn, 32'hAA);
        chk("byp_rm", val_rm, 32'd7);
        wb_en = 1'b0;

        // RAW on EX producer: stall-only stalls, forwarding instance does not
        issue(32'h108, SUB_42I);
        exe_wb_en = 1'b1; exe_dst = 4'd2;
        #1 chk("haz_exe_stall", 32'(hazard_stall), 32'd1);
        chk("haz_exe_fwd", 32'(f_hazard_stall), 32'd0);
        step();
        chk("haz_bubble", 32'(valid), 32'd0);
        chk("haz_fwd_valid", 32'(f_valid), 32'd1);
        chk("haz_fwd_cmd", 32'(f_ex_cmd), 32'h4);
        chk("haz_fwd_rn", f_val_rn, 32'hAA);

        // RAW on MEM producer
        exe_wb_en = 1'b0; mem_wb_en = 1'b1; mem_dst = 4'd2;
        #1 chk("haz_mem_stall", 32'(hazard_stall), 32'd1);
        chk("haz_mem_fwd", 32'(f_hazard_stall), 32'd0);
        mem_wb_en = 1'b0;

        // Load-use stalls both policies
        exe_wb_en = 1'b1; exe_mem_read = 1'b1; exe_dst = 4'd2;
        #1 chk("lu_stall", 32'(hazard_stall), 32'd1);
        chk("lu_fwd_stall", 32'(f_hazard_stall), 32'd1);

        // Immediate operand: Rm field is not a source
        exe_dst = 4'd1;
        #1 chk("imm_no_src2", 32'(hazard_stall), 32'd0);
        chk("imm_no_src2_f", 32'(f_hazard_stall), 32'd0);

        // Flush masks the stall and bubbles ID/EX
        exe_dst = 4'd2; flush = 1'b1;
        #1 chk("flush_nostall", 32'(hazard_stall), 32'd0);
        step();
        chk("flush_bubble", 32'(f_valid), 32'd0);
        flush = 1'b0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;

        // Conditional MOV: fails with Z=0, passes with Z=1
        issue(32'h10C, MOVEQ03);
        status_register = 4'b0000;
        exe_wb_en = 1'b1; exe_dst = 4'd0;
        #1 chk("moveq_f_nostall", 32'(hazard_stall), 32'd0);
        step();
        chk("moveq_f_valid", 32'(valid), 32'd0);
        status_register = 4'b0100;
        #1 chk("mov_no_src1", 32'(hazard_stall), 32'd0);
        step();
        chk("moveq_valid", 32'(valid), 32'd1);
        chk("moveq_cmd", 32'(ex_cmd), 32'h1);
        chk("moveq_imm", 32'(imm), 32'd1);
        chk("moveq_shop", 32'(shifter_operand), 32'h003);
        exe_wb_en = 1'b0; status_register = 4'b0000;

        // Unlisted opcode decodes as a bubble
        issue(32'h110, RSB_123);
        step();
        chk("rsb_bubble", 32'(valid), 32'd0);

        // STR reads Rd as src2; R1 supplied via bypass
        issue(32'h140, STR_12);
        wb_en = 1'b1; wb_dst = 4'd1; wb_data = 32'h11;
        step();
        wb_en = 1'b0;
        chk("str_valid", 32'(valid), 32'd1);
        chk("str_mw", 32'(mem_write), 32'd1);
        chk("str_mr", 32'(mem_read), 32'd0);
        chk("str_wb", 32'(wb_en_out), 32'd0);
        chk("str_cmd", 32'(ex_cmd), 32'h2);
        chk("str_src2", 32'(src2), 32'd1);
        chk("str_rm", val_rm, 32'h11);

        // Freeze holds for three cycles, hazard still reported
        freeze = 1'b1;
        issue(32'h200, ADD_123);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                exe_wb_en = 1'b1; exe_dst = 4'd2;
                #1 chk("frz_stall", 32'(hazard_stall), 32'd1);
            end
            step();
            chk("frz_valid", 32'(valid), 32'd1);
            chk("frz_pc", pc_out, 32'h140);
            chk("frz_mw", 32'(mem_write), 32'd1);
        end
        flush = 1'b1;
        step();
        chk("flfrz_valid", 32'(valid), 32'd0);
        chk("flfrz_mw", 32'(mem_write), 32'd0);
        flush = 1'b0; freeze = 1'b0; exe_wb_en = 1'b0;

        issue(32'h144, LDR_12);
        step();
        chk("ldr_mr", 32'(mem_read), 32'd1);
        chk("ldr_wb", 32'(wb_en_out), 32'd1);
        chk("ldr_rn", val_rn, 32'hAA);

        issue(32'h148, B_10);
        step();
        chk("b_b", 32'(b), 32'd1);
        chk("b_wb", 32'(wb_en_out), 32'd0);
        chk("b_simm", 32'(signed_imm), 32'h10);

        issue(32'h14C, CMP_23);
        step();
        chk("cmp_cmd", 32'(ex_cmd), 32'h4);
        chk("cmp_s", 32'(s_update), 32'd1);
        chk("cmp_wb", 32'(wb_en_out), 32'd0);

        // Asynchronous reset mid-stream, then registers read back 0
        issue(32'h150, ADD_123);
        step();
        chk("pre_rst_valid", 32'(valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_pc", pc_out, 32'd0);
        chk("arst_rn", val_rn, 32'd0);
        step();
        rst = 1'b0;
        issue(32'h154, ADD_123);
        step();
        chk("post_rst_valid", 32'(valid), 32'd1);
        chk("post_rst_rn", val_rn, 32'd0);
        chk("post_rst_rm", val_rm, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_stage_pipelined.md
# id_stage_pipelined

Parametrised decode stage with an integrated ID/EX pipeline register. It sits between the IF/ID register and the execute stage and contains:
- the register file, with same-cycle writeback bypass
- condition check and control decode
- a data-hazard detector that stalls fetch

All outputs toward EX are registered. The hazard policy is selectable between stall-only and forwarding-aware.

## Interface
- WORD_WIDTH, 32, datapath and register width; instruction stays 32 bits
- REG_COUNT, 16, implemented registers (2..16); addresses >= REG_COUNT read 0 and ignore writes
- FORWARDING_EN, 0, 0 = stall on any RAW match; 1 = stall only on load-use

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- freeze  in  1  hold ID/EX register contents
- flush  in  1  branch taken; load bubble into ID/EX
- pc_in  in  WORD_WIDTH  PC of decoding instruction
- instruction_in  in  32  instruction from IF/ID
- status_register  in  4  {N,Z,C,V}
- wb_en, wb_dst, wb_data  in  1/4/WORD_WIDTH  register file write port
- exe_wb_en, exe_dst, exe_mem_read  in  1/4/1  instruction currently in EX
- mem_wb_en, mem_dst  in  1/4  instruction currently in MEM
- hazard_stall  out  1  combinational; IF and IF/ID must hold
- pc_out, val_rn, val_rm  out  WORD_WIDTH  registered
- src1, src2, dst  out  4  registered
- shifter_operand  out  12, registered
- signed_imm  out  24, registered
- ex_cmd  out  4, registered
- mem_read, mem_write, wb_en_out, imm, b, s_update, valid  out  1, registered

## Operation
- Fields: Rn = instr[19:16], Rd = instr[15:12], Rm = instr[3:0].
- src2 = Rd when the instruction is STR, else Rm.
- imm = instr[25]; signed_imm = instr[23:0]; shifter_operand = instr[11:0].
- Decode for mode instr[27:26] = 00, opcode instr[24:21] -> ex_cmd:
  - MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011
  - SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111
  - EOR 0001->1000, CMP 1010->0100, TST 1000->0110
  - All of these set wb_en except CMP and TST.
  - CMP and TST force s_update = 1; for the rest, s_update = instr[20].
- Mode 01 (memory): ex_cmd = 0010.
  - instr[20] = 1 is LDR: mem_read, wb_en.
  - instr[20] = 0 is STR: mem_write.
- Mode 10 is B: b = 1, no wb_en. Mode 11 and unlisted opcodes decode as a bubble.
- has_src1 = 0 for MOV, MVN and B; 1 otherwise. has_src2 = ~imm | mem_write.
- Condition check uses standard ARM codes 0000..1110 (EQ..AL); 1111 evaluates false.
- Register file is REG_COUNT x WORD_WIDTH, written on the rising edge when wb_en = 1.
  - Combinational read with bypass: reading wb_dst while wb_en = 1 returns wb_data.
  - Reset clears all registers to 0.
- Hazard, with cond_ok = condition passes:
  - Match = (has_src1 and Rn == X) or (has_src2 and src2 == X).
  - FORWARDING_EN = 0: hazard_stall = cond_ok & match(X = exe_dst when exe_wb_en, or X = mem_dst when mem_wb_en).
  - FORWARDING_EN = 1: hazard_stall = cond_ok & exe_mem_read & match(exe_dst).
  - hazard_stall is forced 0 while flush = 1.
- Bubble = valid, wb_en_out, mem_read, mem_write, b and s_update all 0; data fields don't-care.
- ID/EX update priority per clock edge:
  1. flush -> bubble
  2. freeze -> hold all outputs
  3. hazard_stall or ~cond_ok -> bubble
  4. otherwise load decoded instruction with valid = 1

## Timing
- Latency is 1 cycle: instruction_in at edge N appears on outputs after edge N+1.
- Throughput is 1 instruction/cycle absent stalls.
- hazard_stall is asserted in the same cycle as the offending instruction. It persists until the producer leaves EX/MEM, which is at most 2 cycles when FORWARDING_EN = 0 and 1 cycle when it is 1.
- Reset: every registered output is 0, hazard state is cleared, and registers are 0. Reset takes effect immediately, including mid-stall.
- Simultaneous wb_en and a read of the same register: the bypass value is what gets registered.
- freeze with hazard_stall: outputs hold; hazard_stall is still driven so IF also holds.
- flush with freeze: flush wins.

## Test plan
- Reset mid-stream: assert rst asynchronously -> all outputs 0 before the next edge; valid = 0.
- ADD R1,R2,R3 with R2 = 5, R3 = 7 -> next cycle: ex_cmd = 0010, val_rn = 5, val_rm = 7, dst = 1, wb_en_out = 1, valid = 1.
- Bypass: wb_en = 1, wb_dst = 2, wb_data = 0xAA in the same cycle ADD reads R2 -> val_rn = 0xAA.
- FORWARDING_EN = 0: exe_wb_en = 1, exe_dst = 2, decoding SUB R4,R2,#1 -> hazard_stall = 1, bubble issued. Repeat with exe_mem_read = 0 under FORWARDING_EN = 1 -> no stall.
- MOVEQ R0,#3 with Z = 0 -> bubble (valid = 0), no stall. Same with Z = 1 -> ex_cmd = 0001, imm = 1.
- Valid STR issued, then freeze = 1 for 3 cycles -> outputs held. Assert flush and freeze together -> bubble on next edge.
